// File: rtl/pixel_sched_pkg.sv
// Shared types and widths for the pixel scheduler and its credit counter.
package pixel_sched_pkg;

   localparam int unsigned X_W     = 11;
   localparam int unsigned Y_W     = 10;
   localparam int unsigned FLOAT_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } sched_state_e;

   // Head position as raw IEEE-754 single-precision bit patterns.
   typedef struct packed {
      logic [FLOAT_W-1:0] x;
      logic [FLOAT_W-1:0] y;
      logic [FLOAT_W-1:0] z;
   } head_pos_t;

endpackage

// File: rtl/credit_counter.sv
// In-flight ray credit counter with registered full flag and sticky underflow error.
module credit_counter #(
   parameter  int unsigned MAX_INFLIGHT = 16,
   localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             underflow_o
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             err_q, err_d;
   logic             inc_ok, dec_ok;

   // Next count: a retire at zero is dropped and flagged; simultaneous inc/dec cancel.
   always_comb begin
      inc_ok  = inc_i && (count_q != MAX_CNT);
      dec_ok  = dec_i && (count_q != '0);
      count_d = count_q;
      if (inc_ok && !dec_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (!inc_ok && dec_ok) begin
         count_d = count_q - CNT_W'(1);
      end
      full_d = (count_d == MAX_CNT);
      err_d  = err_q || (dec_i && (count_q == '0));
   end

   // Counter state registers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         count_q <= '0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         full_q  <= full_d;
         err_q   <= err_d;
      end
   end

   assign count_o     = count_q;
   assign full_o      = full_q;
   assign underflow_o = err_q;

endmodule

// File: rtl/pixel_scheduler.sv
// Frame-level raster scheduler feeding eye_to_pixel, throttled by ray credits.
// Optional statistics counters are built when PIXEL_SCHED_STATS_EN is defined.
module pixel_scheduler
   import pixel_sched_pkg::*;
#(
   parameter  int unsigned H_RES        = 1280,
   parameter  int unsigned V_RES        = 720,
   parameter  int unsigned MAX_INFLIGHT = 16,
   localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               frame_start_in,
   input  logic [FLOAT_W-1:0] head_x_in,
   input  logic [FLOAT_W-1:0] head_y_in,
   input  logic [FLOAT_W-1:0] head_z_in,
   input  logic               retire_in,
   output logic               pix_valid_out,
   output logic [X_W-1:0]     pix_x_out,
   output logic [Y_W-1:0]     pix_y_out,
   output logic [FLOAT_W-1:0] head_x_out,
   output logic [FLOAT_W-1:0] head_y_out,
   output logic [FLOAT_W-1:0] head_z_out,
   output logic               busy_out,
   output logic               frame_done_out,
   output logic [CNT_W-1:0]   inflight_out,
   output logic               err_out
`ifdef PIXEL_SCHED_STATS_EN
   ,
   output logic [31:0]        frame_cycles_out,
   output logic [31:0]        stall_cycles_out
`endif
);

   localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

   sched_state_e   state_q, state_d;
   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   head_pos_t      head_q, head_d;
   logic           pix_valid_q, pix_valid_d;
   logic [X_W-1:0] pix_x_q, pix_x_d;
   logic [Y_W-1:0] pix_y_q, pix_y_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           issue_c;
   logic           full;
   logic [CNT_W-1:0] count;
   logic           err;

   credit_counter #(
      .MAX_INFLIGHT (MAX_INFLIGHT)
   ) u_credit (
      .clk_i       (clk_in),
      .rst_n_i     (rst_in),
      .inc_i       (issue_c),
      .dec_i       (retire_in),
      .count_o     (count),
      .full_o      (full),
      .underflow_o (err)
   );

   // Next-state, raster advance and registered issue outputs.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      head_d      = head_q;
      pix_valid_d = 1'b0;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      done_d      = 1'b0;
      issue_c     = 1'b0;

      case (state_q)
         IDLE: begin
            if (frame_start_in) begin
               state_d  = ISSUE;
               head_d.x = head_x_in;
               head_d.y = head_y_in;
               head_d.z = head_z_in;
               x_d      = '0;
               y_d      = '0;
            end
         end
         ISSUE: begin
            if (!full) begin
               issue_c     = 1'b1;
               pix_valid_d = 1'b1;
               pix_x_d     = x_q;
               pix_y_d     = y_q;
               if (x_q == X_LAST) begin
                  x_d = '0;
                  if (y_q == Y_LAST) begin
                     y_d     = '0;
                     state_d = DRAIN;
                  end else begin
                     y_d = y_q + Y_W'(1);
                  end
               end else begin
                  x_d = x_q + X_W'(1);
               end
            end
         end
         DRAIN: begin
            if (count == '0) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         head_q      <= '0;
         pix_valid_q <= 1'b0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         head_q      <= head_d;
         pix_valid_q <= pix_valid_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign pix_valid_out  = pix_valid_q;
   assign pix_x_out      = pix_x_q;
   assign pix_y_out      = pix_y_q;
   assign head_x_out     = head_q.x;
   assign head_y_out     = head_q.y;
   assign head_z_out     = head_q.z;
   assign busy_out       = busy_q;
   assign frame_done_out = done_q;
   assign inflight_out   = count;
   assign err_out        = err;

`ifdef PIXEL_SCHED_STATS_EN
   logic [31:0] fcyc_q, fcyc_d;
   logic [31:0] stall_q, stall_d;

   // Saturating frame-length and credit-stall counters, cleared on an accepted start.
   always_comb begin
      fcyc_d  = fcyc_q;
      stall_d = stall_q;
      if (state_q == IDLE) begin
         if (frame_start_in) begin
            fcyc_d  = '0;
            stall_d = '0;
         end
      end else begin
         if (fcyc_q != '1) begin
            fcyc_d = fcyc_q + 32'd1;
         end
         if ((state_q == ISSUE) && full && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         fcyc_q  <= '0;
         stall_q <= '0;
      end else begin
         fcyc_q  <= fcyc_d;
         stall_q <= stall_d;
      end
   end

   assign frame_cycles_out = fcyc_q;
   assign stall_cycles_out = stall_q;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pixel_scheduler.sv
module tb_pixel_scheduler;

   localparam int unsigned H = 4;
   localparam int unsigned V = 2;
   localparam int unsigned M = 3;
   localparam int unsigned CW = $clog2(M + 1);

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          frame_start_in;
   logic [31:0]   head_x_in, head_y_in, head_z_in;
   logic          retire_in;
   logic          pix_valid_out;
   logic [10:0]   pix_x_out;
   logic [9:0]    pix_y_out;
   logic [31:0]   head_x_out, head_y_out, head_z_out;
   logic          busy_out;
   logic          frame_done_out;
   logic [CW-1:0] inflight_out;
   logic          err_out;
`ifdef PIXEL_SCHED_STATS_EN
   logic [31:0]   frame_cycles_out, stall_cycles_out;
`endif

   int total = 0;
   int bad   = 0;

   pixel_scheduler #(.H_RES(H), .V_RES(V), .MAX_INFLIGHT(M)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .frame_start_in (frame_start_in),
      .head_x_in      (head_x_in),
      .head_y_in      (head_y_in),
      .head_z_in      (head_z_in),
      .retire_in      (retire_in),
      .pix_valid_out  (pix_valid_out),
      .pix_x_out      (pix_x_out),
      .pix_y_out      (pix_y_out),
      .head_x_out     (head_x_out),
      .head_y_out     (head_y_out),
      .head_z_out     (head_z_out),
      .busy_out       (busy_out),
      .frame_done_out (frame_done_out),
      .inflight_out   (inflight_out),
      .err_out        (err_out)
`ifdef PIXEL_SCHED_STATS_EN
      ,
      .frame_cycles_out (frame_cycles_out),
      .stall_cycles_out (stall_cycles_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      rst_in = 1'b0; frame_start_in = 1'b1; retire_in = 1'b1;
      head_x_in = 32'hDEADBEEF; head_y_in = 32'h12345678; head_z_in = 32'h0BADF00D;
      for (int i = 0; i < 3; i++) tick();
      total++; if (pix_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", pix_valid_out); end
      total++; if ({pix_x_out, pix_y_out} !== 21'd0) begin bad++; $display("FAIL reset_xy got=%0d,%0d want=0,0", pix_x_out, pix_y_out); end
      total++; if ({head_x_out, head_y_out, head_z_out} !== 96'd0) begin bad++; $display("FAIL reset_head got=%h %h %h want=0", head_x_out, head_y_out, head_z_out); end
      total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_out); end
      total++; if (frame_done_out !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", frame_done_out); end
      total++; if (inflight_out !== CW'(0)) begin bad++; $display("FAIL reset_inflight got=%0d want=0", inflight_out); end
      total++; if (err_out !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_out); end
`ifdef PIXEL_SCHED_STATS_EN
      total++; if ({frame_cycles_out, stall_cycles_out} !== 64'd0) begin bad++; $display("FAIL reset_stats got=%0d,%0d want=0,0", frame_cycles_out, stall_cycles_out); end
`endif
      frame_start_in = 1'b0; retire_in = 1'b0;
      rst_in = 1'b1;
      tick();
      total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy_out); end
   endtask

   // Whole frame with retires from the second issue; optionally pokes frame_start and head_x mid-frame.
   task automatic test_full_frame(input bit poke, input logic [31:0] hx);
      head_x_in = hx; head_y_in = 32'h3F800000; head_z_in = 32'h40000000;
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      total++; if (busy_out !== 1'b1 || pix_valid_out !== 1'b0) begin bad++; $display("FAIL ff_start busy=%b valid=%b want=1,0", busy_out, pix_valid_out); end
      total++; if (head_x_out !== hx || head_y_out !== 32'h3F800000 || head_z_out !== 32'h40000000) begin bad++; $display("FAIL ff_head got=%h %h %h want=%h 3f800000 40000000", head_x_out, head_y_out, head_z_out, hx); end
      if (poke) head_x_in = 32'h0;
      for (int k = 1; k <= 8; k++) begin
         if (poke && k == 3) frame_start_in = 1'b1;
         tick();
         frame_start_in = 1'b0;
         total++; if (pix_valid_out !== 1'b1 || pix_x_out !== 11'((k - 1) % 4) || pix_y_out !== 10'((k - 1) / 4)) begin
            bad++; $display("FAIL ff_pixel%0d got v=%b (%0d,%0d) want v=1 (%0d,%0d)", k, pix_valid_out, pix_x_out, pix_y_out, (k - 1) % 4, (k - 1) / 4);
         end
         if (poke) begin
            total++; if (head_x_out !== hx) begin bad++; $display("FAIL ff_head_hold%0d got=%h want=%h", k, head_x_out, hx); end
         end
         if (k == 2) retire_in = 1'b1;
      end
      total++; if (inflight_out !== CW'(2)) begin bad++; $display("FAIL ff_inflight_last got=%0d want=2", inflight_out); end
      tick();
      total++; if (pix_valid_out !== 1'b0 || busy_out !== 1'b1 || inflight_out !== CW'(1)) begin bad++; $display("FAIL ff_drain got v=%b busy=%b infl=%0d want 0,1,1", pix_valid_out, busy_out, inflight_out); end
      tick();
      retire_in = 1'b0;
      total++; if (inflight_out !== CW'(0) || frame_done_out !== 1'b0) begin bad++; $display("FAIL ff_empty got infl=%0d done=%b want 0,0", inflight_out, frame_done_out); end
      tick();
      total++; if (frame_done_out !== 1'b1 || busy_out !== 1'b0) begin bad++; $display("FAIL ff_done got done=%b busy=%b want 1,0", frame_done_out, busy_out); end
`ifdef PIXEL_SCHED_STATS_EN
      total++; if (frame_cycles_out !== 32'd11) begin bad++; $display("FAIL ff_frame_cycles got=%0d want=11", frame_cycles_out); end
`endif
      tick();
      total++; if (frame_done_out !== 1'b0 || err_out !== 1'b0 || busy_out !== 1'b0) begin bad++; $display("FAIL ff_after got done=%b err=%b busy=%b want 0,0,0", frame_done_out, err_out, busy_out); end
   endtask

   task automatic test_credit_stall();
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         total++; if (pix_valid_out !== 1'b1 || pix_x_out !== 11'(k - 1) || pix_y_out !== 10'd0 || inflight_out !== CW'(k)) begin
            bad++; $display("FAIL cs_issue%0d got v=%b (%0d,%0d) infl=%0d want 1 (%0d,0) %0d", k, pix_valid_out, pix_x_out, pix_y_out, inflight_out, k - 1, k);
         end
      end
      for (int k = 4; k <= 13; k++) begin
         tick();
         retire_in = 1'b0;
         total++; if (pix_valid_out !== 1'b0 || inflight_out !== CW'((k == 13) ? 2 : 3)) begin
            bad++; $display("FAIL cs_stall%0d got v=%b infl=%0d want 0 %0d", k, pix_valid_out, inflight_out, (k == 13) ? 2 : 3);
         end
`ifdef PIXEL_SCHED_STATS_EN
         if (k == 13) begin
            total++; if (stall_cycles_out !== 32'd10) begin bad++; $display("FAIL cs_stall_count got=%0d want=10", stall_cycles_out); end
         end
`endif
         if (k == 12) retire_in = 1'b1;
      end
      tick();
      total++; if (pix_valid_out !== 1'b1 || pix_x_out !== 11'd3 || pix_y_out !== 10'd0 || inflight_out !== CW'(3)) begin
         bad++; $display("FAIL cs_resume got v=%b (%0d,%0d) infl=%0d want 1 (3,0) 3", pix_valid_out, pix_x_out, pix_y_out, inflight_out);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (pix_valid_out !== 1'b0) begin bad++; $display("FAIL cs_one_only%0d got v=%b want 0", k, pix_valid_out); end
      end
      rst_in = 1'b0;
      tick();
      rst_in = 1'b1;
   endtask

   task automatic test_mid_reset();
      total++; if (head_x_out !== 32'h44E10001) begin bad++; $display("FAIL hs_idle_hold got=%h want=44e10001", head_x_out); end
      head_x_in = 32'h0;
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      total++; if (head_x_out !== 32'h0) begin bad++; $display("FAIL hs_new_latch got=%h want=0", head_x_out); end
      for (int k = 1; k <= 5; k++) begin
         tick();
         total++; if (pix_valid_out !== 1'b1 || pix_x_out !== 11'((k - 1) % 4) || pix_y_out !== 10'((k - 1) / 4)) begin
            bad++; $display("FAIL mr_pixel%0d got v=%b (%0d,%0d) want 1 (%0d,%0d)", k, pix_valid_out, pix_x_out, pix_y_out, (k - 1) % 4, (k - 1) / 4);
         end
         if (k == 2) retire_in = 1'b1;
      end
      rst_in = 1'b0; retire_in = 1'b0;
      tick();
      rst_in = 1'b1;
      total++; if (pix_valid_out !== 1'b0 || inflight_out !== CW'(0) || busy_out !== 1'b0) begin
         bad++; $display("FAIL mr_reset got v=%b infl=%0d busy=%b want 0 0 0", pix_valid_out, inflight_out, busy_out);
      end
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      tick();
      total++; if (pix_valid_out !== 1'b1 || pix_x_out !== 11'd0 || pix_y_out !== 10'd0) begin
         bad++; $display("FAIL mr_restart got v=%b (%0d,%0d) want 1 (0,0)", pix_valid_out, pix_x_out, pix_y_out);
      end
      rst_in = 1'b0;
      tick();
      rst_in = 1'b1;
      tick();
   endtask

   task automatic test_errors();
      total++; if (err_out !== 1'b0) begin bad++; $display("FAIL er_before got=%b want=0", err_out); end
      retire_in = 1'b1;
      tick();
      retire_in = 1'b0;
      total++; if (err_out !== 1'b1 || inflight_out !== CW'(0)) begin bad++; $display("FAIL er_set got err=%b infl=%0d want 1 0", err_out, inflight_out); end
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (err_out !== 1'b1 || inflight_out !== CW'(0) || busy_out !== 1'b0) begin
            bad++; $display("FAIL er_sticky%0d got err=%b infl=%0d busy=%b want 1 0 0", k, err_out, inflight_out, busy_out);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_frame(1'b0, 32'h3F000000);
      test_credit_stall();
      test_full_frame(1'b1, 32'h44E10001);
      test_mid_reset();
      test_errors();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
